avmm_to_axil: RTL

- Avalon-MM agent to AXI4-Lite master bridge. It is the opposite end of the CSR path from axil_to_avmm.
- Lets an Avalon-MM host (an app_mat-style CSR initiator or management sequencer) issue single-beat register accesses onto the AXI-Lite fabric.
- Supports one outstanding transaction at a time. Read data and write completion are returned to Avalon with mapped response codes.

---
 rtl/avmm_axil_pkg.sv | 39 +++
 rtl/avmm_to_axil_wr_chan.sv | 64 ++++++
 rtl/avmm_to_axil.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/avmm_axil_pkg.sv
// Shared definitions for the Avalon-MM to AXI4-Lite bridge.
//   - state_t           : bridge FSM state encoding
//   - RESP_*            : Avalon-MM response codes
//   - AXI_*             : AXI4-Lite BRESP/RRESP codes
//   - AXI_PROT_DEFAULT  : fixed AxPROT value (unprivileged, secure, data)
//   - axi_to_avmm_resp  : maps an AXI response onto an Avalon response
package avmm_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_OKAY    = 2'b00;
  localparam logic [1:0] AXI_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_DECERR  = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // EXOKAY has no Avalon counterpart; it is a successful access, so OKAY.
  function automatic logic [1:0] axi_to_avmm_resp(input logic [1:0] resp);
    case (resp)
      AXI_OKAY:   return RESP_OKAY;
      AXI_EXOKAY: return RESP_OKAY;
      AXI_SLVERR: return RESP_SLVERR;
      AXI_DECERR: return RESP_DECERR;
      default:    return RESP_OKAY;
    endcase
  endfunction

endpackage

// File: rtl/avmm_to_axil_wr_chan.sv
// AW/W issue tracker for the Avalon-MM to AXI4-Lite bridge.
// Raises AWVALID and WVALID together on start_i and retires each one on its
// own handshake, in either order or in the same cycle. issue_done_o reports
// that both channels have been accepted (including a handshake happening
// this very cycle), and is only meaningful while the bridge is in ST_WR.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   start_i        write accepted this cycle; launch AW and W
//   awready_i      AXI AWREADY
//   wready_i       AXI WREADY
//   awvalid_o      AXI AWVALID (registered)
//   wvalid_o       AXI WVALID  (registered)
//   issue_done_o   both AW and W have been (or are being) accepted
module avmm_to_axil_wr_chan (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic issue_done_o
);

  logic awvalid_q;
  logic wvalid_q;
  logic aw_done_q;
  logic w_done_q;
  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & awready_i;
  assign w_hs  = wvalid_q  & wready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (start_i) begin
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid_q <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid_q <= 1'b0;
        w_done_q <= 1'b1;
      end
    end
  end

  // Counting the in-cycle handshake lets the FSM leave ST_WR on the same
  // edge that retires the last channel, keeping the minimum write latency.
  assign issue_done_o = (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign awvalid_o    = awvalid_q;
  assign wvalid_o     = wvalid_q;

endmodule

// File: rtl/avmm_to_axil.sv
// Avalon-MM agent to AXI4-Lite master bridge, one outstanding access.
// An Avalon command is accepted when read or write is high while
// waitrequest is low; the bridge then runs a single AXI-Lite transaction
// and returns readdatavalid / writeresponsevalid with a mapped response.
// If read and write are asserted together the write is issued and the read
// is dropped.
// Optional feature: define AVMM_TO_AXIL_ERR_CNT_EN to count completed B/R
// beats whose response has bit 1 set (SLVERR/DECERR) in a saturating
// counter on err_count; otherwise err_count is tied to zero.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   csr_agent_*                    Avalon-MM agent (command + responses)
//   m_axil_aw* / w* / b*           AXI4-Lite write address/data/response
//   m_axil_ar* / r*                AXI4-Lite read address/data
//   err_count                      error counter (0 without the feature)
module avmm_to_axil
  import avmm_axil_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    csr_agent_address,
  input  logic                     csr_agent_read,
  input  logic                     csr_agent_write,
  input  logic [DATA_WIDTH-1:0]    csr_agent_writedata,
  input  logic [STRB_WIDTH-1:0]    csr_agent_byteenable,
  output logic                     csr_agent_waitrequest,
  output logic [DATA_WIDTH-1:0]    csr_agent_readdata,
  output logic                     csr_agent_readdatavalid,
  output logic                     csr_agent_writeresponsevalid,
  output logic [1:0]               csr_agent_response,
  output logic [ADDR_WIDTH-1:0]    m_axil_awaddr,
  output logic [2:0]               m_axil_awprot,
  output logic                     m_axil_awvalid,
  input  logic                     m_axil_awready,
  output logic [DATA_WIDTH-1:0]    m_axil_wdata,
  output logic [STRB_WIDTH-1:0]    m_axil_wstrb,
  output logic                     m_axil_wvalid,
  input  logic                     m_axil_wready,
  input  logic [1:0]               m_axil_bresp,
  input  logic                     m_axil_bvalid,
  output logic                     m_axil_bready,
  output logic [ADDR_WIDTH-1:0]    m_axil_araddr,
  output logic [2:0]               m_axil_arprot,
  output logic                     m_axil_arvalid,
  input  logic                     m_axil_arready,
  input  logic [DATA_WIDTH-1:0]    m_axil_rdata,
  input  logic [1:0]               m_axil_rresp,
  input  logic                     m_axil_rvalid,
  output logic                     m_axil_rready,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("avmm_to_axil: DATA_WIDTH must be 32");
  end

  state_t                  state_q;
  logic                    wait_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    rready_q;
  logic                    rdv_q;
  logic                    wrv_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;

  logic                    wr_start;
  logic                    wr_issue_done;

  // wait_q is low only in IDLE, so this is exactly the Avalon accept edge
  // for a write (which also wins over a simultaneous read).
  assign wr_start = (state_q == ST_IDLE) && !wait_q && csr_agent_write;

  avmm_to_axil_wr_chan u_wr_chan (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (wr_start),
    .awready_i    (m_axil_awready),
    .wready_i     (m_axil_wready),
    .awvalid_o    (m_axil_awvalid),
    .wvalid_o     (m_axil_wvalid),
    .issue_done_o (wr_issue_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= 1'b1;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rdv_q     <= 1'b0;
      wrv_q     <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      rdv_q <= 1'b0;
      wrv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // waitrequest is still high only on the first cycle after reset
          if (wait_q) begin
            wait_q <= 1'b0;
          end else if (csr_agent_write || csr_agent_read) begin
            wait_q  <= 1'b1;
            addr_q  <= csr_agent_address;
            wdata_q <= csr_agent_writedata;
            wstrb_q <= csr_agent_byteenable;
            if (csr_agent_write) begin
              state_q <= ST_WR;
            end else begin
              state_q   <= ST_RD;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (wr_issue_done) begin
            state_q  <= ST_WR_RESP;
            bready_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (m_axil_bvalid) begin
            bready_q <= 1'b0;
            wrv_q    <= 1'b1;
            resp_q   <= axi_to_avmm_resp(m_axil_bresp);
            wait_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axil_rvalid) begin
            rready_q <= 1'b0;
            rdv_q    <= 1'b1;
            rdata_q  <= m_axil_rdata;
            resp_q   <= axi_to_avmm_resp(m_axil_rresp);
            wait_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          wait_q    <= 1'b1;
          arvalid_q <= 1'b0;
          bready_q  <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign csr_agent_waitrequest        = wait_q;
  assign csr_agent_readdata           = rdata_q;
  assign csr_agent_readdatavalid      = rdv_q;
  assign csr_agent_writeresponsevalid = wrv_q;
  assign csr_agent_response           = resp_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = AXI_PROT_DEFAULT;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

`ifdef AVMM_TO_AXIL_ERR_CNT_EN
  logic                     err_evt;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // bready/rready are high throughout the *_RESP states, so valid alone
  // marks the completing beat.
  assign err_evt = ((state_q == ST_WR_RESP) && m_axil_bvalid && m_axil_bresp[1]) ||
                   ((state_q == ST_RD_RESP) && m_axil_rvalid && m_axil_rresp[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_evt && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule
